// File: rtl/rv_decode_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcode constants,
// unified ALU / branch / memory op encodings and the per-lane result bundle.
package rv_decode_pkg;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] ILTYPE = 7'b0000011;
    localparam logic [6:0] STYPE  = 7'b0100011;
    localparam logic [6:0] BTYPE  = 7'b1100011;
    localparam logic [6:0] IJTYPE = 7'b1101111;
    localparam logic [6:0] IITYPE = 7'b1100111;
    localparam logic [6:0] U1TYPE = 7'b0110111;
    localparam logic [6:0] U2TYPE = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // Values equal the branch funct3 so decode is a direct cast.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } br_op_e;

    // {is_store, funct3}; MEM_NONE marks a non-memory instruction.
    typedef enum logic [3:0] {
        MEM_LB   = 4'h0,
        MEM_LH   = 4'h1,
        MEM_LW   = 4'h2,
        MEM_LBU  = 4'h4,
        MEM_LHU  = 4'h5,
        MEM_SB   = 4'h8,
        MEM_SH   = 4'h9,
        MEM_SW   = 4'hA,
        MEM_NONE = 4'hF
    } mem_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        br_op_e  br_op;
        mem_op_e mem_op;
        logic    illegal;
    } lane_dec_t;

    // Shared funct3 -> ALU op map; alt selects SUB/SRA.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                            input logic       alt);
        alu_op_e op;
        op = ALU_ADD;
        unique case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_lane_decode.sv
// Combinational single-lane RV32I decoder: 32-bit instruction to lane_dec_t.
// Ports: instr_i (instruction word), dec_o (decoded ops; all-zero but illegal=1 if illegal).
module rv_lane_decode
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output lane_dec_t   dec_o
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    lane_dec_t  d;
    logic       unused_bits;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    // Register and immediate fields play no part in the op decode.
    assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        d.alu_op  = ALU_ADD;
        d.br_op   = BR_BEQ;
        d.mem_op  = MEM_NONE;
        d.illegal = 1'b0;
        unique case (opc)
            RTYPE: begin
                if (f7 == 7'h00) begin
                    d.alu_op = alu_from_f3(f3, 1'b0);
                end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    d.alu_op = alu_from_f3(f3, 1'b1);
                end else begin
                    d.illegal = 1'b1;
                end
            end
            ITYPE: begin
                // Only shift-immediates carry a funct7; bit30 elsewhere is imm.
                if (f3 == 3'b001) begin
                    d.alu_op  = ALU_SLL;
                    d.illegal = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'h00)      d.alu_op = ALU_SRL;
                    else if (f7 == 7'h20) d.alu_op = ALU_SRA;
                    else                  d.illegal = 1'b1;
                end else begin
                    d.alu_op = alu_from_f3(f3, 1'b0);
                end
            end
            ILTYPE: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                    d.illegal = 1'b1;
                else
                    d.mem_op = mem_op_e'({1'b0, f3});
            end
            STYPE: begin
                if (f3 >= 3'd3)
                    d.illegal = 1'b1;
                else
                    d.mem_op = mem_op_e'({1'b1, f3});
            end
            BTYPE: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    d.illegal = 1'b1;
                end else begin
                    d.alu_op = ALU_SUB;
                    d.br_op  = br_op_e'(f3);
                end
            end
            IITYPE: d.illegal = (f3 != 3'b000);
            U1TYPE: d.alu_op  = ALU_PASSB;
            IJTYPE, U2TYPE: d.alu_op = ALU_ADD;
            default: d.illegal = 1'b1;
        endcase
        dec_o = d.illegal ? lane_dec_t'({$bits(lane_dec_t){1'b0}} | 1'b1) : d;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered multi-lane decode stage with a 2-entry skid buffer (MAIN/SKID),
// registered in_ready and a saturating illegal-lane counter.
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_instr upstream;
// out_valid/out_ready/out_alu_op/out_br_op/out_mem_op/out_illegal downstream;
// illegal_cnt (saturating count of delivered illegal lanes).
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int LANES    = 1,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*LANES-1:0]       in_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_OP_W*LANES-1:0] out_alu_op,
    output logic [3*LANES-1:0]        out_br_op,
    output logic [4*LANES-1:0]        out_mem_op,
    output logic [LANES-1:0]          out_illegal,
    output logic [CNT_W-1:0]          illegal_cnt
);

    lane_dec_t [LANES-1:0] dec;
    lane_dec_t [LANES-1:0] main_q, main_d;
    lane_dec_t [LANES-1:0] skid_q, skid_d;
    logic                  main_v_q, main_v_d;
    logic                  skid_v_q, skid_v_d;
    logic                  rdy_q, rdy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            pop;
    logic [CNT_W+2:0]      sum;
    logic                  accept;
    logic                  out_hs;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [3:0] alu_raw;

        rv_lane_decode u_dec (
            .instr_i (in_instr[32*k +: 32]),
            .dec_o   (dec[k])
        );

        assign alu_raw                        = main_q[k].alu_op;
        assign out_alu_op[ALU_OP_W*k +: ALU_OP_W] = ALU_OP_W'(alu_raw);
        assign out_br_op[3*k +: 3]            = main_q[k].br_op;
        assign out_mem_op[4*k +: 4]           = main_q[k].mem_op;
        assign out_illegal[k]                 = main_q[k].illegal;
    end

    assign accept      = in_valid & rdy_q;
    assign out_hs      = main_v_q & out_ready;
    assign in_ready    = rdy_q;
    assign out_valid   = main_v_q;
    assign illegal_cnt = cnt_q;

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++)
            pop = pop + {2'b00, main_q[k].illegal};
        sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, pop};
    end

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (out_hs) begin
                if (sum > {3'b000, {CNT_W{1'b1}}})
                    cnt_d = '1;
                else
                    cnt_d = sum[CNT_W-1:0];
            end
            // rdy_q is low whenever SKID is full, so accept implies SKID empty.
            if (out_hs && skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (out_hs || !main_v_q) begin
                main_v_d = accept;
                if (accept) main_d = dec;
            end else if (accept) begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
        end
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
            cnt_q    <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage: one single-lane instance
// (16-bit counter) and one two-lane instance (2-bit counter).
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        flush1 = 1'b0, v1 = 1'b0, rdy1, ov1, ordy1 = 1'b0;
    logic [31:0] instr1 = '0;
    logic [3:0]  alu1, mem1;
    logic [2:0]  br1;
    logic [0:0]  ill1;
    logic [15:0] cnt1;

    logic        flush2 = 1'b0, v2 = 1'b0, rdy2, ov2, ordy2 = 1'b0;
    logic [63:0] instr2 = '0;
    logic [7:0]  alu2, mem2;
    logic [5:0]  br2;
    logic [1:0]  ill2;
    logic [1:0]  cnt2;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_AND  = 32'h00B57533;
    localparam logic [31:0] I_MUL  = 32'h02B50533;
    localparam logic [31:0] I_JBAD = 32'h00003067;
    localparam logic [31:0] I_BLT  = 32'h0000C063;
    localparam logic [31:0] I_LUI  = 32'h123450B7;

    always #5 clk = ~clk;

    rv_decode_stage #(.LANES(1), .ALU_OP_W(4), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(v1), .in_ready(rdy1), .in_instr(instr1),
        .out_valid(ov1), .out_ready(ordy1),
        .out_alu_op(alu1), .out_br_op(br1), .out_mem_op(mem1),
        .out_illegal(ill1), .illegal_cnt(cnt1)
    );

    rv_decode_stage #(.LANES(2), .ALU_OP_W(4), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(v2), .in_ready(rdy2), .in_instr(instr2),
        .out_valid(ov2), .out_ready(ordy2),
        .out_alu_op(alu2), .out_br_op(br2), .out_mem_op(mem2),
        .out_illegal(ill2), .illegal_cnt(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (ov1 !== 1'b0) $display("FAIL reset_ov1 got %b want 0", ov1);
        else passed++;
        total++;
        if (rdy1 !== 1'b1) $display("FAIL reset_rdy1 got %b want 1", rdy1);
        else passed++;
        total++;
        if ({alu1, br1, mem1, ill1, cnt1} !== 28'h0)
            $display("FAIL reset_data1 got %h want 0", {alu1, br1, mem1, ill1, cnt1});
        else passed++;
        total++;
        if ({ov2, rdy2, cnt2, alu2, mem2} !== 20'h40000)
            $display("FAIL reset_u2 got %h want 40000", {ov2, rdy2, cnt2, alu2, mem2});
        else passed++;
    endtask

    task automatic test_sub();
        v1 = 1'b1; instr1 = I_SUB; ordy1 = 1'b1;
        tick();
        v1 = 1'b0;
        total++;
        if ({ov1, alu1, br1, mem1, ill1} !== {1'b1, 4'd1, 3'd0, 4'hF, 1'b0})
            $display("FAIL sub_decode got %b want 1_0001_000_1111_0", {ov1, alu1, br1, mem1, ill1});
        else passed++;
        tick();
        total++;
        if ({ov1, alu1} !== {1'b0, 4'd1})
            $display("FAIL sub_drain got %b want 0_0001", {ov1, alu1});
        else passed++;
    endtask

    task automatic test_stall();
        ordy1 = 1'b0; v1 = 1'b1; instr1 = I_ADD;
        tick();
        total++;
        if ({ov1, rdy1} !== 2'b11) $display("FAIL stall_first got %b want 11", {ov1, rdy1});
        else passed++;
        instr1 = I_AND;
        tick();
        v1 = 1'b0;
        total++;
        if ({ov1, rdy1, alu1} !== {2'b10, 4'd0})
            $display("FAIL stall_full got %b want 10_0000", {ov1, rdy1, alu1});
        else passed++;
        tick();
        total++;
        if ({ov1, rdy1, alu1} !== {2'b10, 4'd0})
            $display("FAIL stall_hold got %b want 10_0000", {ov1, rdy1, alu1});
        else passed++;
        ordy1 = 1'b1;
        tick();
        total++;
        if ({ov1, rdy1, alu1} !== {2'b11, 4'd9})
            $display("FAIL stall_second got %b want 11_1001", {ov1, rdy1, alu1});
        else passed++;
        tick();
        total++;
        if (ov1 !== 1'b0) $display("FAIL stall_drain got %b want 0", ov1);
        else passed++;
    endtask

    task automatic test_illegal();
        ordy1 = 1'b1; v1 = 1'b1; instr1 = I_MUL;
        tick();
        total++;
        if ({ov1, ill1, alu1, br1, mem1, cnt1} !== {2'b11, 11'd0, 16'd0})
            $display("FAIL illegal_mul got %h want %h", {ov1, ill1, alu1, br1, mem1, cnt1}, {2'b11, 27'd0});
        else passed++;
        instr1 = I_JBAD;
        tick();
        v1 = 1'b0;
        total++;
        if ({ov1, ill1, alu1, br1, mem1, cnt1} !== {2'b11, 11'd0, 16'd1})
            $display("FAIL illegal_jalr got %h want %h", {ov1, ill1, alu1, br1, mem1, cnt1}, {2'b11, 27'd1});
        else passed++;
        tick();
        total++;
        if ({ov1, cnt1} !== {1'b0, 16'd2})
            $display("FAIL illegal_cnt got %h want %h", {ov1, cnt1}, {1'b0, 16'd2});
        else passed++;
    endtask

    task automatic test_flush();
        ordy1 = 1'b0; v1 = 1'b1; instr1 = I_MUL;
        tick();
        instr1 = I_ADD;
        tick();
        total++;
        if ({ov1, rdy1} !== 2'b10) $display("FAIL flush_setup got %b want 10", {ov1, rdy1});
        else passed++;
        flush1 = 1'b1; ordy1 = 1'b1;
        tick();
        flush1 = 1'b0; v1 = 1'b0; ordy1 = 1'b0;
        total++;
        if ({ov1, rdy1, cnt1} !== {2'b01, 16'd2})
            $display("FAIL flush_full got %h want %h", {ov1, rdy1, cnt1}, {2'b01, 16'd2});
        else passed++;
        v1 = 1'b1; flush1 = 1'b1; instr1 = I_ADD;
        tick();
        v1 = 1'b0; flush1 = 1'b0;
        total++;
        if ({ov1, rdy1} !== 2'b01) $display("FAIL flush_drop got %b want 01", {ov1, rdy1});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vi [8] = '{I_ADD, I_SUB, 32'h40555513, 32'h40050513,
                                32'h40151513, 32'h00052503, 32'h00A52023, I_LUI};
        logic [3:0]  va [8] = '{4'd0, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10};
        logic [3:0]  vm [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h2, 4'hA, 4'hF};
        logic        vl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ordy1 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr1 = vi[i];
            tick();
            total++;
            if ({ov1, alu1, mem1, ill1} !== {1'b1, va[i], vm[i], vl[i]})
                $display("FAIL b2b_%0d got %b want %b", i, {ov1, alu1, mem1, ill1},
                         {1'b1, va[i], vm[i], vl[i]});
            else passed++;
        end
        v1 = 1'b0;
        tick();
        total++;
        if ({ov1, cnt1} !== {1'b0, 16'd3})
            $display("FAIL b2b_cnt got %h want %h", {ov1, cnt1}, {1'b0, 16'd3});
        else passed++;
    endtask

    task automatic test_lanes2();
        ordy2 = 1'b1; v2 = 1'b1; instr2 = {I_LUI, I_BLT};
        tick();
        v2 = 1'b0;
        total++;
        if ({ov2, alu2, br2, mem2, ill2} !== {1'b1, 8'hA1, 6'h04, 8'hFF, 2'b00})
            $display("FAIL lanes2 got %h want %h", {ov2, alu2, br2, mem2, ill2},
                     {1'b1, 8'hA1, 6'h04, 8'hFF, 2'b00});
        else passed++;
        tick();
    endtask

    task automatic test_saturate();
        ordy2 = 1'b1; v2 = 1'b1; instr2 = {I_MUL, I_JBAD};
        tick();
        total++;
        if ({ill2, cnt2} !== 4'b1100) $display("FAIL sat_0 got %b want 1100", {ill2, cnt2});
        else passed++;
        tick();
        total++;
        if ({ill2, cnt2} !== 4'b1110) $display("FAIL sat_2 got %b want 1110", {ill2, cnt2});
        else passed++;
        instr2 = {I_ADD, I_MUL};
        tick();
        v2 = 1'b0;
        total++;
        if ({ill2, mem2, cnt2} !== {2'b01, 8'hF0, 2'd3})
            $display("FAIL sat_3 got %h want %h", {ill2, mem2, cnt2}, {2'b01, 8'hF0, 2'd3});
        else passed++;
        tick();
        total++;
        if ({ov2, cnt2} !== 3'b011) $display("FAIL sat_hold got %b want 011", {ov2, cnt2});
        else passed++;
    endtask

    task automatic test_async_reset();
        ordy1 = 1'b0; v1 = 1'b1; instr1 = I_AND;
        tick();
        v1 = 1'b0;
        total++;
        if (ov1 !== 1'b1) $display("FAIL arst_pre got %b want 1", ov1);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ov1, rdy1, alu1, cnt1} !== {2'b01, 4'd0, 16'd0})
            $display("FAIL arst_async got %h want %h", {ov1, rdy1, alu1, cnt1}, {2'b01, 20'd0});
        else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_sub();
        test_stall();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_lanes2();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
